// File: rtl/pic16_tmr0_wdt.sv
// Timer0, shared 8-bit prescaler and watchdog for the PIC16-compatible core.
// TMR0/OPTION sit on the special-register bus; T0IF and WDT_TO feed the core's flag and reset logic.
module pic16_tmr0_wdt #(
    parameter bit          WDT_EN   = 1'b1,
    parameter logic [17:0] WDT_BASE = 18'd18000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       WE,
    input  logic [8:0] ADDR,
    input  logic [7:0] WDATA,
    output logic [7:0] RDATA,
    output logic       HIT,
    input  logic       T0CKI,
    input  logic       WDT_CLR,
    input  logic       SLEEP,
    input  logic       T0IF_CLR,
    output logic       T0IF,
    output logic       WDT_TO
);

    // Ones in bits [n-1:0]; n = 0 yields an empty mask.
    function automatic logic [7:0] low_mask(input logic [2:0] n);
        low_mask = ~(8'hFF << n);
    endfunction

    logic [7:0]  option_q, option_d;
    logic [7:0]  tmr0_q, tmr0_d;
    logic [7:0]  pre_q, pre_d;
    logic [17:0] wdt_q, wdt_d;
    logic [1:0]  inh_q, inh_d;
    logic        t0if_q, t0if_d;
    logic        wdt_to_q, wdt_to_d;
    logic        s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;

    logic        psa, hit_reg, wr_tmr0, wr_opt;
    logic        pin_edge, src_event, tmr_tick, tmr_inc, base_tick, wdt_timeout, pre_clr;
    logic [7:0]  tmr_mask, wdt_mask;

    // RP1 only selects a bank mirror; both registers appear in every bank pair.
    logic        addr_rp1_unused;
    assign addr_rp1_unused = ADDR[8];

    // Next-state logic for timer, prescaler, watchdog and pin synchronizer.
    always_comb begin
        psa         = option_q[3];
        hit_reg     = (ADDR[6:0] == 7'h01);
        wr_tmr0     = WE & (ADDR[7:0] == 8'h01);
        wr_opt      = WE & (ADDR[7:0] == 8'h81);
        tmr_mask    = (low_mask(option_q[2:0]) << 1) | 8'h01;
        wdt_mask    = low_mask(option_q[2:0]);
        pin_edge    = option_q[4] ? (s3_q & ~s2_q) : (s2_q & ~s3_q);
        src_event   = option_q[5] ? pin_edge : ~SLEEP;
        tmr_tick    = src_event & (psa | ((pre_q & tmr_mask) == tmr_mask));
        tmr_inc     = tmr_tick & (inh_q == 2'd0);
        base_tick   = (WDT_EN == 1'b1) && (wdt_q == (WDT_BASE - 18'd1));
        wdt_timeout = base_tick & (~psa | ((pre_q & wdt_mask) == wdt_mask));
        pre_clr     = (wr_tmr0 & ~psa) | (wr_opt & (WDATA[3] != psa))
                    | (psa & (WDT_CLR | wdt_timeout));

        option_d = wr_opt ? WDATA : option_q;
        s1_d     = T0CKI;
        s2_d     = s1_q;
        s3_d     = s2_q;
        wdt_to_d = wdt_timeout & ~WDT_CLR;

        if (wr_tmr0) begin
            tmr0_d = WDATA;
            inh_d  = 2'd2;
        end else begin
            tmr0_d = tmr_inc ? (tmr0_q + 8'd1) : tmr0_q;
            inh_d  = (inh_q != 2'd0) ? (inh_q - 2'd1) : 2'd0;
        end

        if (~wr_tmr0 & tmr_inc & (tmr0_q == 8'hFF)) begin
            t0if_d = 1'b1;
        end else if (T0IF_CLR) begin
            t0if_d = 1'b0;
        end else begin
            t0if_d = t0if_q;
        end

        if (pre_clr) begin
            pre_d = 8'd0;
        end else if ((~psa & src_event) | (psa & base_tick)) begin
            pre_d = pre_q + 8'd1;
        end else begin
            pre_d = pre_q;
        end

        if (WDT_EN != 1'b1) begin
            wdt_d = 18'd0;
        end else if (WDT_CLR | base_tick) begin
            wdt_d = 18'd0;
        end else begin
            wdt_d = wdt_q + 18'd1;
        end
    end

    // Special-register read port.
    always_comb begin
        HIT = hit_reg;
        if (hit_reg) begin
            RDATA = ADDR[7] ? option_q : tmr0_q;
        end else begin
            RDATA = 8'h00;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            option_q <= 8'hFF;
            tmr0_q   <= 8'h00;
            pre_q    <= 8'h00;
            wdt_q    <= 18'd0;
            inh_q    <= 2'd0;
            t0if_q   <= 1'b0;
            wdt_to_q <= 1'b0;
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            s3_q     <= 1'b0;
        end else begin
            option_q <= option_d;
            tmr0_q   <= tmr0_d;
            pre_q    <= pre_d;
            wdt_q    <= wdt_d;
            inh_q    <= inh_d;
            t0if_q   <= t0if_d;
            wdt_to_q <= wdt_to_d;
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            s3_q     <= s3_d;
        end
    end

    assign T0IF   = t0if_q;
    assign WDT_TO = wdt_to_q;

endmodule

// File: tb/tb_pic16_tmr0_wdt.sv
// Directed and randomized bench for pic16_tmr0_wdt against a behavioural model.
module tb_pic16_tmr0_wdt;

    localparam int BASE = 4;

    logic       CLK, RST, WE, T0CKI, WDT_CLR, SLEEP, T0IF_CLR;
    logic [8:0] ADDR;
    logic [7:0] WDATA, RDATA;
    logic       HIT, T0IF, WDT_TO;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state
    logic [7:0] m_opt, m_tmr;
    int         m_pre, m_base, m_inh;
    logic       m_t0if, m_to;
    logic       pin_hist [3];

    logic [8:0] addr_list [7] = '{9'h001, 9'h101, 9'h081, 9'h181, 9'h003, 9'h0C1, 9'h041};

    pic16_tmr0_wdt #(.WDT_EN(1'b1), .WDT_BASE(18'd4)) dut (
        .CLK(CLK), .RST(RST), .WE(WE), .ADDR(ADDR), .WDATA(WDATA), .RDATA(RDATA),
        .HIT(HIT), .T0CKI(T0CKI), .WDT_CLR(WDT_CLR), .SLEEP(SLEEP),
        .T0IF_CLR(T0IF_CLR), .T0IF(T0IF), .WDT_TO(WDT_TO)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_opt = 8'hFF; m_tmr = 8'h00; m_pre = 0; m_base = 0; m_inh = 0;
        m_t0if = 1'b0; m_to = 1'b0;
        for (int i = 0; i < 3; i++) pin_hist[i] = 1'b0;
    endtask

    function automatic logic [7:0] exp_rdata();
        if (ADDR[6:0] != 7'h01) return 8'h00;
        return ADDR[7] ? m_opt : m_tmr;
    endfunction

    // Advance the model by one clock using the inputs present before the edge.
    task automatic model_update();
        bit psa, wr_t, wr_o, ev, tick, btick, to, ovf, clr;
        int ps;
        psa  = m_opt[3];
        ps   = int'(m_opt[2:0]);
        wr_t = WE && (ADDR[7:0] == 8'h01);
        wr_o = WE && (ADDR[7:0] == 8'h81);
        // pin_hist[1] / [2] are the pin samples taken two and three edges ago
        if (m_opt[5])
            ev = m_opt[4] ? (pin_hist[1] == 1'b0 && pin_hist[2] == 1'b1)
                          : (pin_hist[1] == 1'b1 && pin_hist[2] == 1'b0);
        else
            ev = !SLEEP;
        tick  = psa ? ev : (ev && ((m_pre + 1) % (2 << ps) == 0));
        btick = (m_base == BASE - 1);
        to    = btick && (psa ? ((m_pre + 1) % (1 << ps) == 0) : 1'b1);
        ovf   = 1'b0;
        if (wr_t) begin
            m_tmr = WDATA;
            m_inh = 2;
        end else begin
            if (tick && m_inh == 0) begin
                ovf   = (m_tmr == 8'hFF);
                m_tmr = m_tmr + 8'd1;
            end
            if (m_inh > 0) m_inh--;
        end
        if (ovf) m_t0if = 1'b1;
        else if (T0IF_CLR) m_t0if = 1'b0;
        clr = (wr_t && !psa) || (wr_o && (WDATA[3] != psa)) || (psa && (WDT_CLR || to));
        if (clr) m_pre = 0;
        else if ((!psa && ev) || (psa && btick)) m_pre = (m_pre + 1) % 256;
        m_base = (WDT_CLR || btick) ? 0 : m_base + 1;
        m_to   = to && !WDT_CLR;
        if (wr_o) m_opt = WDATA;
        pin_hist[2] = pin_hist[1];
        pin_hist[1] = pin_hist[0];
        pin_hist[0] = T0CKI;
    endtask

    task automatic step();
        @(posedge CLK);
        model_update();
        #1;
        chk("rdata", RDATA, exp_rdata());
        chk("hit", HIT, (ADDR[6:0] == 7'h01));
        chk("t0if", T0IF, m_t0if);
        chk("wdt_to", WDT_TO, m_to);
    endtask

    task automatic wr(input logic [8:0] a, input logic [7:0] d);
        WE = 1'b1; ADDR = a; WDATA = d;
        step();
        WE = 1'b0; ADDR = 9'h001;
        #1;
    endtask

    task automatic idle_inputs();
        WE = 1'b0; ADDR = 9'h001; WDATA = 8'h00; T0CKI = 1'b0;
        WDT_CLR = 1'b0; SLEEP = 1'b0; T0IF_CLR = 1'b0;
    endtask

    task automatic rand_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            WE       = ($urandom_range(7) == 0);
            ADDR     = addr_list[$urandom_range(6)];
            WDATA    = 8'($urandom);
            T0CKI    = ($urandom_range(2) == 0) ? ~T0CKI : T0CKI;
            WDT_CLR  = ($urandom_range(15) == 0);
            SLEEP    = ($urandom_range(3) == 0);
            T0IF_CLR = ($urandom_range(7) == 0);
            step();
        end
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) begin
            T0CKI = 1'b1; step(); step();
            T0CKI = 1'b0; step(); step();
        end
    endtask

    initial begin
        int first_to, cnt;
        idle_inputs();
        RST = 1'b1;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_tmr0", RDATA, 8'h00);
        chk("rst_t0if", T0IF, 1'b0);
        chk("rst_wdt_to", WDT_TO, 1'b0);
        ADDR = 9'h081; #1;
        chk("rst_option", RDATA, 8'hFF);
        ADDR = 9'h001;
        RST = 1'b0;

        // Watchdog after reset: PS=7 gives 128 base ticks
        first_to = 0;
        for (int i = 1; i <= 520; i++) begin
            step();
            if (WDT_TO === 1'b1 && first_to == 0) first_to = i;
        end
        chk("wdt_first_to", first_to, 128 * BASE);

        // TMR0 write inhibit and overflow
        wr(9'h081, 8'h08);
        wr(9'h001, 8'hFE);
        chk("inh_k", RDATA, 8'hFE);
        step(); chk("inh_k1", RDATA, 8'hFE);
        step(); chk("inh_k2", RDATA, 8'hFE);
        step(); chk("inc_k3", RDATA, 8'hFF);
        step(); chk("ovf_k4", RDATA, 8'h00);
        chk("ovf_t0if", T0IF, 1'b1);

        T0IF_CLR = 1'b1; step(); T0IF_CLR = 1'b0;
        chk("t0if_clr", T0IF, 1'b0);
        wr(9'h001, 8'hFF);
        step(); step();
        T0IF_CLR = 1'b1; step(); T0IF_CLR = 1'b0;
        chk("set_wins_tmr", RDATA, 8'h00);
        chk("set_wins_t0if", T0IF, 1'b1);

        // Prescaler 1:4 on TMR0
        wr(9'h081, 8'h01);
        wr(9'h001, 8'h00);
        repeat (16) step();
        chk("ps14_count", RDATA, 8'h04);
        repeat (2) step();
        wr(9'h001, 8'h10);
        repeat (3) step();
        chk("ps14_restart_hold", RDATA, 8'h10);
        step();
        chk("ps14_restart_inc", RDATA, 8'h11);

        // External clock, rising then falling edges
        wr(9'h081, 8'h28);
        wr(9'h001, 8'h00);
        repeat (3) step();
        pulses(3);
        repeat (3) step();
        chk("t0cki_rise", RDATA, 8'h03);
        wr(9'h081, 8'h38);
        wr(9'h001, 8'h00);
        repeat (3) step();
        pulses(3);
        repeat (3) step();
        chk("t0cki_fall", RDATA, 8'h03);

        // Watchdog 1:2 with base 4
        wr(9'h081, 8'h09);
        WDT_CLR = 1'b1; step(); WDT_CLR = 1'b0;
        cnt = 0;
        repeat (32) begin
            step();
            if (WDT_TO === 1'b1) cnt++;
        end
        chk("wdt_pulses", cnt, 4);
        cnt = 0;
        for (int i = 0; i < 48; i++) begin
            WDT_CLR = (i % 6 == 0);
            step();
            if (WDT_TO === 1'b1) cnt++;
        end
        WDT_CLR = 1'b0;
        chk("wdt_cleared", cnt, 0);

        rand_cycles(2000);

        // Asynchronous reset between edges
        idle_inputs();
        wr(9'h081, 8'h00);
        wr(9'h001, 8'hA5);
        repeat (3) step();
        #3;
        RST = 1'b1;
        #1;
        chk("arst_tmr0", RDATA, 8'h00);
        chk("arst_t0if", T0IF, 1'b0);
        chk("arst_wdt_to", WDT_TO, 1'b0);
        ADDR = 9'h081; #1;
        chk("arst_option", RDATA, 8'hFF);
        ADDR = 9'h001;
        model_reset();
        RST = 1'b0;

        rand_cycles(500);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
